// File: rtl/shift_reg_flow_ctrl.sv
// shift_reg_flow_ctrl
//   Valid/ready flow controller for one enable-only shift_reg of DEPTH stages.
//   It drives the shift enable and keeps a per-stage valid mask. Together they
//   turn the plain delay line into a stallable, flushable streaming stage.
//   Only control is handled here; data runs from din through the shift_reg.
// Ports
//   clk, rst_n        clock, async active-low reset
//   s_valid/s_ready   upstream handshake (data goes to shift_reg din)
//   m_valid/m_ready   downstream handshake (data at shift_reg dout)
//   flush             discard all contents (sampled in RUN only)
//   sr_ena            shift enable to the shift_reg
//   flush_busy        high while flushing
//   flush_done        one-cycle pulse when a flush completes
//   occupancy         number of valid words held in the line
module shift_reg_flow_ctrl #(
  parameter int  DEPTH = 7,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             m_valid,
  input  logic             m_ready,
  input  logic             flush,
  output logic             sr_ena,
  output logic             flush_busy,
  output logic             flush_done,
  output logic [CNT_W-1:0] occupancy
);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t           state;
  logic [DEPTH-1:0] vmask;      // bit DEPTH-1 is the head (dout) stage
  logic [DEPTH-1:0] vmask_nxt;
  logic [CNT_W-1:0] fcnt;
  logic             run;
  logic             head;
  logic             s_hs;
  logic             m_hs;
  logic             in_bit;

  // The line only freezes when the head holds a word nobody takes; a bubble
  // at the head never blocks. In FLUSH the line free-runs and zeros shift in.
  always_comb begin
    run       = (state == RUN);
    head      = vmask[DEPTH-1];
    m_valid   = run & head;
    sr_ena    = ~run | ~head | m_ready;
    s_ready   = run & sr_ena;
    s_hs      = s_valid & s_ready;
    m_hs      = m_valid & m_ready;
    in_bit    = run & s_valid;
    // Shift-in written as a truncating cast so DEPTH=1 needs no special case.
    vmask_nxt = DEPTH'({vmask, in_bit});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      vmask      <= '0;
      occupancy  <= '0;
      fcnt       <= '0;
      flush_done <= 1'b0;
      flush_busy <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      case (state)
        RUN: begin
          if (sr_ena) vmask <= vmask_nxt;
          if (s_hs && !m_hs)      occupancy <= occupancy + CNT_W'(1);
          else if (!s_hs && m_hs) occupancy <= occupancy - CNT_W'(1);
          // Handshakes of the flush-request cycle still complete above.
          if (flush) begin
            state      <= FLUSH;
            fcnt       <= CNT_W'(DEPTH);
            flush_busy <= 1'b1;
          end
        end
        FLUSH: begin
          if (fcnt == CNT_W'(1)) begin
            state      <= RUN;
            vmask      <= '0;
            occupancy  <= '0;
            fcnt       <= '0;
            flush_busy <= 1'b0;
            flush_done <= 1'b1;
          end else begin
            vmask <= vmask_nxt;
            fcnt  <= fcnt - CNT_W'(1);
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_reg_flow_ctrl.sv
// Directed bench for shift_reg_flow_ctrl: a DEPTH=7 instance and a DEPTH=1
// instance, each wrapped around a small shift_reg data line.
module tb_shift_reg_flow_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // DEPTH=7 instance
  logic       a_sv = 1'b0, a_sr, a_mv, a_mr = 1'b0, a_fl = 1'b0, a_ena, a_fb, a_fd;
  logic [2:0] a_occ;
  logic [7:0] a_din = 8'd0;
  logic [7:0] sra [7];
  logic [7:0] a_dout;
  logic [7:0] got_a [$];

  // DEPTH=1 instance
  logic       b_sv = 1'b0, b_sr, b_mv, b_mr = 1'b0, b_fl = 1'b0, b_ena, b_fb, b_fd;
  logic [0:0] b_occ;
  logic [7:0] b_din = 8'd0;
  logic [7:0] srb;
  logic [7:0] got_b [$];

  shift_reg_flow_ctrl #(.DEPTH(7)) u_a (
    .clk(clk), .rst_n(rst_n), .s_valid(a_sv), .s_ready(a_sr), .m_valid(a_mv),
    .m_ready(a_mr), .flush(a_fl), .sr_ena(a_ena), .flush_busy(a_fb),
    .flush_done(a_fd), .occupancy(a_occ));

  shift_reg_flow_ctrl #(.DEPTH(1)) u_b (
    .clk(clk), .rst_n(rst_n), .s_valid(b_sv), .s_ready(b_sr), .m_valid(b_mv),
    .m_ready(b_mr), .flush(b_fl), .sr_ena(b_ena), .flush_busy(b_fb),
    .flush_done(b_fd), .occupancy(b_occ));

  // Data lines (unreset, as the real shift_reg)
  always_ff @(posedge clk) begin
    if (a_ena) begin
      sra[0] <= a_din;
      for (int i = 1; i < 7; i++) sra[i] <= sra[i-1];
    end
    if (b_ena) srb <= b_din;
  end
  assign a_dout = sra[6];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Sample handshakes mid-cycle, cross the edge, then present the next word.
  task automatic cyc_a();
    logic acc;
    #2;
    acc = a_sv & a_sr;
    if (a_mv && a_mr) got_a.push_back(a_dout);
    @(posedge clk); #1;
    if (acc) a_din = a_din + 8'd1;
  endtask

  task automatic cyc_b();
    logic acc;
    #2;
    acc = b_sv & b_sr;
    if (b_mv && b_mr) got_b.push_back(srb);
    @(posedge clk); #1;
    if (acc) b_din = b_din + 8'd1;
  endtask

  initial begin
    int first, last, ok, cnt, maxocc, bad;
    logic [15:0] mvbits;
    logic [7:0]  exp_w;

    // ---- reset state
    #2;
    chk("rst_s_ready", a_sr, 1);
    chk("rst_m_valid", a_mv, 0);
    chk("rst_sr_ena", a_ena, 1);
    chk("rst_flush_busy", a_fb, 0);
    chk("rst_flush_done", a_fd, 0);
    chk("rst_occ", a_occ, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // ---- 1: continuous stream 1..20
    got_a.delete(); a_din = 8'd1; a_sv = 1'b1; a_mr = 1'b1; first = -1; last = -1;
    for (int c = 0; c < 32; c++) begin
      if (c == 20) a_sv = 1'b0;
      #1;
      if (a_mv) begin
        if (first < 0) first = c;
        last = c;
      end
      if (c == 10) chk("t1_occ_full", a_occ, 7);
      cyc_a();
    end
    chk("t1_first_valid_cycle", first, 7);
    chk("t1_last_valid_cycle", last, 26);
    chk("t1_count", got_a.size(), 20);
    ok = 0;
    for (int i = 0; i < got_a.size(); i++) if (got_a[i] == 8'(i + 1)) ok++;
    chk("t1_order", ok, 20);
    chk("t1_occ_end", a_occ, 0);

    // ---- 2: backpressure
    got_a.delete(); a_din = 8'd101; a_sv = 1'b1; a_mr = 1'b0;
    for (int c = 0; c < 7; c++) begin #1; cyc_a(); end
    for (int s = 0; s < 5; s++) begin
      #1;
      chk("t2_sr_ena", a_ena, 0);
      chk("t2_s_ready", a_sr, 0);
      chk("t2_m_valid", a_mv, 1);
      chk("t2_dout", a_dout, 101);
      chk("t2_occ", a_occ, 7);
      cyc_a();
    end
    a_mr = 1'b1;
    for (int c = 0; c < 19; c++) begin
      if (c == 5) a_sv = 1'b0;
      #1; cyc_a();
    end
    chk("t2_count", got_a.size(), 12);
    ok = 0;
    for (int i = 0; i < got_a.size(); i++) if (got_a[i] == 8'(101 + i)) ok++;
    chk("t2_order", ok, 12);

    // ---- 3: bubbles 1,0,0,1
    got_a.delete(); a_din = 8'd31; a_mr = 1'b1; mvbits = '0; maxocc = 0;
    for (int c = 0; c < 16; c++) begin
      a_sv = (c == 0 || c == 3);
      #1;
      mvbits[c] = a_mv;
      if (int'(a_occ) > maxocc) maxocc = int'(a_occ);
      cyc_a();
    end
    a_sv = 1'b0;
    chk("t3_mvalid_pattern", mvbits, 16'h0480);
    chk("t3_occ_peak", maxocc, 2);
    chk("t3_count", got_a.size(), 2);
    if (got_a.size() == 2) begin
      chk("t3_word0", got_a[0], 31);
      chk("t3_word1", got_a[1], 32);
    end

    // ---- 4: flush at occupancy 4
    a_din = 8'd201; a_sv = 1'b1;
    for (int c = 0; c < 4; c++) begin #1; cyc_a(); end
    a_sv = 1'b0; a_fl = 1'b1;
    #1;
    chk("t4_occ_pre", a_occ, 4);
    chk("t4_busy_pre", a_fb, 0);
    got_a.delete();
    cyc_a();
    a_fl = 1'b0; a_sv = 1'b1; cnt = 0;
    for (int f = 0; f < 7; f++) begin
      a_fl = (f == 2);
      #1;
      chk("t4_flush_busy", a_fb, 1);
      chk("t4_m_valid", a_mv, 0);
      chk("t4_s_ready", a_sr, 0);
      chk("t4_sr_ena", a_ena, 1);
      if (a_fd) cnt++;
      cyc_a();
    end
    a_fl = 1'b0; a_sv = 1'b0;
    #1;
    chk("t4_done", a_fd, 1);
    chk("t4_busy_after", a_fb, 0);
    chk("t4_occ_after", a_occ, 0);
    if (a_fd) cnt++;
    cyc_a();
    #1;
    if (a_fd) cnt++;
    chk("t4_done_pulses", cnt, 1);
    chk("t4_no_output", got_a.size(), 0);
    chk("t4_din_held", a_din, 205);
    // next word after flush: full latency
    got_a.delete(); a_din = 8'd250; first = -1;
    for (int c = 0; c < 12; c++) begin
      a_sv = (c == 0);
      if (c > 0) #1;
      if (a_mv && first < 0) first = c;
      cyc_a();
    end
    a_sv = 1'b0;
    chk("t4_latency", first, 7);
    chk("t4_post_count", got_a.size(), 1);
    if (got_a.size() == 1) chk("t4_post_word", got_a[0], 250);

    // ---- 5: reset in the 3rd FLUSH cycle with occupancy 5
    a_din = 8'd40; a_sv = 1'b1;
    for (int c = 0; c < 5; c++) begin #1; cyc_a(); end
    a_sv = 1'b0; a_fl = 1'b1;
    #1;
    chk("t5_occ_pre", a_occ, 5);
    cyc_a();
    a_fl = 1'b0;
    for (int f = 0; f < 2; f++) begin #1; cyc_a(); end
    #1;
    chk("t5_busy_before_rst", a_fb, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_m_valid", a_mv, 0);
    chk("t5_occ", a_occ, 0);
    chk("t5_busy", a_fb, 0);
    chk("t5_done", a_fd, 0);
    chk("t5_s_ready", a_sr, 1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (a_fd) cnt++;
      cyc_a();
    end
    chk("t5_no_done", cnt, 0);

    // ---- 6: DEPTH=1, alternating m_ready
    got_b.delete(); b_din = 8'd1; bad = 0;
    for (int c = 0; c < 20; c++) begin
      b_sv = 1'b1;
      b_mr = (c % 2 == 0);
      #1;
      if (b_occ > 1'b1 || (b_occ == 1'b0 && b_mv)) bad++;
      cyc_b();
    end
    b_sv = 1'b0; b_mr = 1'b1;
    for (int c = 0; c < 4; c++) begin #1; cyc_b(); end
    #1;
    chk("t6_occ_bound", bad, 0);
    chk("t6_count", got_b.size(), 10);
    ok = 0;
    exp_w = 8'd1;
    foreach (got_b[i]) begin
      if (got_b[i] == exp_w) ok++;
      exp_w = exp_w + 8'd1;
    end
    chk("t6_order", ok, 10);
    chk("t6_occ_end", b_occ, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
